lutram_readback_checker: RTL and testbench

LUTRAM_READBACK_CHECKER -- requirements
Module: lutram_readback_checker

---
 rtl/lutram_chk_pkg.sv | 13 +
 rtl/lutram_readback_checker_sat_counter.sv | 33 +++
 rtl/lutram_readback_checker.sv | 140 ++++++++++++++
 tb/tb_lutram_readback_checker.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lutram_chk_pkg.sv
// Shared FSM encoding and default widths for the LUTRAM readback checker.
package lutram_chk_pkg;

    localparam int unsigned DEF_A_WIDTH = 7;
    localparam int unsigned DEF_ERR_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/lutram_readback_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/lutram_readback_checker.sv
// Two-stage readback checker for an alternating-pattern LUTRAM test pass.
// Define CHECK_DPO_EN to also compare the dual-port read data.
module lutram_readback_checker
    import lutram_chk_pkg::*;
#(
    parameter int unsigned A_WIDTH = DEF_A_WIDTH,
    parameter int unsigned ERR_W   = DEF_ERR_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               rd_valid_i,
    input  logic [A_WIDTH-1:0] rd_addr_i,
    input  logic               spo_i,
    input  logic               dpo_i,
    output logic               done_o,
    output logic               pass_o,
    output logic [ERR_W-1:0]   err_count_o,
    output logic [A_WIDTH-1:0] first_err_addr_o,
    output logic               seq_err_o
);

    state_e             state_q, state_d;
    logic               s1_vld_q, s1_vld_d;
    logic [A_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic               s1_spo_q, s1_spo_d;
    logic [A_WIDTH-1:0] exp_q, exp_d;
    logic [A_WIDTH-1:0] first_q, first_d;
    logic               seq_q, seq_d;
    logic               done_q, done_d;
    logic               cnt_clr, cnt_inc;
    logic [ERR_W-1:0]   err_cnt;
    logic               addr_mis, data_mis;

`ifdef CHECK_DPO_EN
    logic s1_dpo_q, s1_dpo_d;
    assign data_mis = (s1_spo_q != s1_addr_q[0]) || (s1_dpo_q != s1_addr_q[0]);
`else
    logic dpo_unused;
    assign dpo_unused = dpo_i;
    assign data_mis   = (s1_spo_q != s1_addr_q[0]);
`endif

    assign addr_mis = (s1_addr_q != exp_q);

    always_comb begin
        state_d   = state_q;
        s1_vld_d  = 1'b0;
        s1_addr_d = s1_addr_q;
        s1_spo_d  = s1_spo_q;
`ifdef CHECK_DPO_EN
        s1_dpo_d  = s1_dpo_q;
`endif
        exp_d     = exp_q;
        first_d   = first_q;
        seq_d     = seq_q;
        done_d    = done_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;

        if (start_i) begin
            state_d = CHECK;
            exp_d   = '0;
            first_d = '0;
            seq_d   = 1'b0;
            done_d  = 1'b0;
            cnt_clr = 1'b1;
        end else if (state_q == CHECK) begin
            s1_vld_d  = rd_valid_i;
            s1_addr_d = rd_addr_i;
            s1_spo_d  = spo_i;
`ifdef CHECK_DPO_EN
            s1_dpo_d  = dpo_i;
`endif
            if (s1_vld_q) begin
                exp_d = exp_q + A_WIDTH'(1);
                if (addr_mis) begin
                    seq_d = 1'b1;
                end
                // One error per sample, whichever comparisons failed.
                if (addr_mis || data_mis) begin
                    cnt_inc = 1'b1;
                    if (err_cnt == '0) begin
                        first_d = s1_addr_q;
                    end
                end
                if (exp_q == '1) begin
                    done_d   = 1'b1;
                    state_d  = DONE;
                    s1_vld_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_spo_q  <= 1'b0;
`ifdef CHECK_DPO_EN
            s1_dpo_q  <= 1'b0;
`endif
            exp_q     <= '0;
            first_q   <= '0;
            seq_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_vld_q  <= s1_vld_d;
            s1_addr_q <= s1_addr_d;
            s1_spo_q  <= s1_spo_d;
`ifdef CHECK_DPO_EN
            s1_dpo_q  <= s1_dpo_d;
`endif
            exp_q     <= exp_d;
            first_q   <= first_d;
            seq_q     <= seq_d;
            done_q    <= done_d;
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .count_o (err_cnt)
    );

    assign done_o           = done_q;
    assign pass_o           = done_q && (err_cnt == '0);
    assign err_count_o      = err_cnt;
    assign first_err_addr_o = first_q;
    assign seq_err_o        = seq_q;

endmodule

// File: tb/tb_lutram_readback_checker.sv
// Bench for lutram_readback_checker: directed passes, reference model, per-cycle compare.
module tb_lutram_readback_checker;

`ifdef CHECK_DPO_EN
    localparam bit DPO_EN = 1'b1;
`else
    localparam bit DPO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rd_valid = 1'b0;
    logic [6:0] rd_addr = '0;
    logic       spo = 1'b0;
    logic       dpo = 1'b0;

    logic       done8, pass8, seq8;
    logic [7:0] err8;
    logic [6:0] first8;
    logic       done2, pass2, seq2;
    logic [1:0] err2;
    logic [6:0] first2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lutram_readback_checker #(.A_WIDTH(7), .ERR_W(8)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .rd_valid_i(rd_valid),
        .rd_addr_i(rd_addr), .spo_i(spo), .dpo_i(dpo), .done_o(done8), .pass_o(pass8),
        .err_count_o(err8), .first_err_addr_o(first8), .seq_err_o(seq8)
    );

    lutram_readback_checker #(.A_WIDTH(7), .ERR_W(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .rd_valid_i(rd_valid),
        .rd_addr_i(rd_addr), .spo_i(spo), .dpo_i(dpo), .done_o(done2), .pass_o(pass2),
        .err_count_o(err2), .first_err_addr_o(first2), .seq_err_o(seq2)
    );

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int sat(int v, int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Reference model: a pass accepts strobes while active; each accepted
    // sample is judged one clock later against the running expected address.
    typedef struct {
        logic [6:0] addr;
        logic       spo;
        logic       dpo;
    } samp_t;

    samp_t      pend[$];
    bit         m_active = 1'b0;
    bit         m_done = 1'b0;
    bit         m_seq = 1'b0;
    int         m_err = 0;
    int         m_exp = 0;
    logic [6:0] m_first = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0; m_done = 1'b0; m_seq = 1'b0;
            m_err = 0; m_exp = 0; m_first = '0;
            pend.delete();
        end else if (start) begin
            m_active = 1'b1; m_done = 1'b0; m_seq = 1'b0;
            m_err = 0; m_exp = 0; m_first = '0;
            pend.delete();
        end else begin : mdl
            bit    acc;
            bit    bad;
            samp_t s;
            acc = m_active && rd_valid;
            if (pend.size() > 0) begin
                s = pend.pop_front();
                bad = (int'(s.addr) != m_exp) || (s.spo != s.addr[0]) ||
                      (DPO_EN && (s.dpo != s.addr[0]));
                if (int'(s.addr) != m_exp) m_seq = 1'b1;
                if (bad) begin
                    if (m_err == 0) m_first = s.addr;
                    m_err++;
                end
                if (m_exp == 127) begin
                    m_done = 1'b1;
                    m_active = 1'b0;
                    acc = 1'b0;
                end
                m_exp = (m_exp + 1) % 128;
            end
            if (acc) pend.push_back('{rd_addr, spo, dpo});
        end
    end

    always @(negedge clk) begin
        chk("done8",  int'(done8),  int'(m_done));
        chk("pass8",  int'(pass8),  int'(m_done && (m_err == 0)));
        chk("err8",   int'(err8),   sat(m_err, 255));
        chk("first8", int'(first8), int'(m_first));
        chk("seq8",   int'(seq8),   int'(m_seq));
        chk("done2",  int'(done2),  int'(m_done));
        chk("pass2",  int'(pass2),  int'(m_done && (m_err == 0)));
        chk("err2",   int'(err2),   sat(m_err, 3));
        chk("first2", int'(first2), int'(m_first));
        chk("seq2",   int'(seq2),   int'(m_seq));
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive(input logic [6:0] a, input logic s, input logic d);
        @(negedge clk);
        rd_valid = 1'b1;
        rd_addr  = a;
        spo      = s;
        dpo      = d;
    endtask

    task automatic end_stream();
        @(negedge clk);
        rd_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin : stim
        logic [6:0] ad;

        repeat (2) @(negedge clk);
        chk("rst_done", int'(done8), 0);
        chk("rst_err",  int'(err8), 0);
        chk("rst_pass", int'(pass8), 0);
        rst_n = 1'b1;

        // Clean full pass, with the two-cycle latency to done pinned.
        do_start();
        for (int i = 0; i < 128; i++) begin
            ad = 7'(i);
            drive(ad, ad[0], ad[0]);
        end
        @(negedge clk);
        rd_valid = 1'b0;
        chk("lat_done_early", int'(done8), 0);
        @(negedge clk);
        chk("clean_done", int'(done8), 1);
        chk("clean_pass", int'(pass8), 1);
        chk("clean_err",  int'(err8), 0);

        // spo stuck 0 at an even (expects 0) and odd address.
        do_start();
        for (int i = 0; i < 128; i++) begin
            ad = 7'(i);
            drive(ad, (i == 4 || i == 9) ? 1'b0 : ad[0], ad[0]);
        end
        end_stream();
        chk("stuck_err",   int'(err8), 1);
        chk("stuck_first", int'(first8), 9);
        chk("stuck_pass",  int'(pass8), 0);

        // Address 3 skipped: every later sample is off by one.
        do_start();
        for (int i = 0; i < 127; i++) begin
            ad = (i < 3) ? 7'(i) : 7'(i + 1);
            drive(ad, ad[0], ad[0]);
        end
        end_stream();
        chk("skip_seq",   int'(seq8), 1);
        chk("skip_first", int'(first8), 4);
        chk("skip_err8",  int'(err8), 124);
        chk("skip_done",  int'(done8), 0);

        // All spo inverted: narrow counter saturates.
        do_start();
        for (int i = 0; i < 128; i++) begin
            ad = 7'(i);
            drive(ad, ~ad[0], ad[0]);
        end
        end_stream();
        chk("inv_err8", int'(err8), 128);
        chk("inv_err2", int'(err2), 3);
        chk("inv_done", int'(done8), 1);
        chk("inv_pass", int'(pass8), 0);

        // Reset mid-pass at address 60; later strobes ignored until start.
        do_start();
        for (int i = 0; i < 60; i++) begin
            ad = 7'(i);
            drive(ad, (i == 7) ? ~ad[0] : ad[0], ad[0]);
        end
        drive(7'(60), 1'b0, 1'b0);
        chk("pre_rst_err",   int'(err8), 1);
        chk("pre_rst_first", int'(first8), 7);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_err",   int'(err8), 0);
        chk("async_rst_first", int'(first8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 61; i < 128; i++) begin
            ad = 7'(i);
            drive(ad, ~ad[0], ad[0]);
        end
        end_stream();
        chk("post_rst_err",  int'(err8), 0);
        chk("post_rst_done", int'(done8), 0);

        // Restart coincident with the final compare wins.
        do_start();
        for (int i = 0; i < 128; i++) begin
            ad = 7'(i);
            drive(ad, ad[0], ad[0]);
        end
        @(negedge clk);
        rd_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_done", int'(done8), 0);

        // dpo inverted at address 1.
        for (int i = 0; i < 128; i++) begin
            ad = 7'(i);
            drive(ad, ad[0], (i == 1) ? ~ad[0] : ad[0]);
        end
        end_stream();
        chk("dpo_done", int'(done8), 1);
        chk("dpo_err",  int'(err8), DPO_EN ? 1 : 0);
        chk("dpo_pass", int'(pass8), DPO_EN ? 0 : 1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
